// File: rtl/fir_pkg.sv
// Shared types and arithmetic helpers for the time-multiplexed FIR.
// Functions take a wide operand so one helper serves any width.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DONE
  } state_e;

  localparam int MAXW = 128;

  function automatic int acc_w(
    input int n,
    input int cw,
    input int taps
  );
    return n + cw + $clog2(taps);
  endfunction

  // Clamp v to the signed n-bit range, or pass through for wrap;
  // the caller keeps the low n bits.
  function automatic logic signed [MAXW-1:0] sat_trunc(
    input logic signed [MAXW-1:0] v,
    input int                     n,
    input bit                     sat
  );
    logic signed [MAXW-1:0] hi;
    logic signed [MAXW-1:0] lo;
    hi = {MAXW{1'b1}} >> (MAXW - n + 1);
    lo = ~hi;
    if (!sat)    return v;
    if (v > hi)  return hi;
    if (v < lo)  return lo;
    return v;
  endfunction

  function automatic int ptr_wrap(
    input int p,
    input int taps
  );
    return ((p % taps) + taps) % taps;
  endfunction

endpackage

// File: rtl/fir_mac_n_delay_line.sv
// Per-channel circular sample buffers with one write and one read port.
// Reads are addressed relative to the newest sample of a channel.
module fir_delay_line
  import fir_pkg::*;
#(
  parameter int N        = 32,
  parameter int TAPS     = 4,
  parameter int CHANNELS = 1,
  parameter int CHW      = 1,
  parameter int AW       = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [CHW-1:0]      wch,
  input  logic signed [N-1:0] wdata,
  input  logic [CHW-1:0]      rch,
  input  logic [AW-1:0]       rk,
  output logic signed [N-1:0] rdata
);

  logic signed [N-1:0] mem_q [CHANNELS][TAPS];
  logic signed [N-1:0] mem_d [CHANNELS][TAPS];
  logic [AW-1:0]       ptr_q [CHANNELS];
  logic [AW-1:0]       ptr_d [CHANNELS];

  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    if (we) begin
      mem_d[wch][ptr_q[wch]] = wdata;
      ptr_d[wch] = AW'(ptr_wrap(int'(ptr_q[wch]) + 1, TAPS));
    end
  end

  // The pointer marks the next free slot, so the newest is one behind it.
  always_comb begin
    rdata = mem_q[rch][AW'(ptr_wrap(int'(ptr_q[rch]) - 1 - int'(rk), TAPS))];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        ptr_q[c] <= '0;
        for (int t = 0; t < TAPS; t++) begin
          mem_q[c][t] <= '0;
        end
      end
    end else begin
      mem_q <= mem_d;
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/fir_mac_n.sv
// Multi-channel FIR sharing one multiply-accumulate over TAPS cycles.
// Holds coefficients, the control FSM, the accumulator and output stage.
module fir_mac_n
  import fir_pkg::*;
#(
  parameter int N        = 32,
  parameter int COEF_W   = 32,
  parameter int TAPS     = 4,
  parameter int CHANNELS = 1,
  parameter int SHIFT    = 0,
  parameter int SATURATE = 1,
  localparam int CHW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int AW      = $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic signed [N-1:0]      in_data,
  input  logic [CHW-1:0]           in_ch,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     coef_we,
  input  logic [AW-1:0]            coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic signed [N-1:0]      out_data,
  output logic [CHW-1:0]           out_ch,
  output logic                     out_valid
);

  localparam int ACC_W = acc_w(N, COEF_W, TAPS);
  localparam int PW    = N + COEF_W;

  state_e                    state_q, state_d;
  logic [AW-1:0]             k_q, k_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [CHW-1:0]            ch_q, ch_d;
  logic signed [COEF_W-1:0]  coef_q [TAPS];
  logic signed [COEF_W-1:0]  coef_d [TAPS];
  logic signed [N-1:0]       odata_q, odata_d;
  logic [CHW-1:0]            och_q, och_d;
  logic                      ov_q, ov_d;

  logic                      accept;
  logic                      ch_ok;
  logic signed [N-1:0]       x;
  logic signed [COEF_W-1:0]  b;
  logic signed [PW-1:0]      x_ext;
  logic signed [PW-1:0]      b_ext;
  logic signed [PW-1:0]      prod;
  logic signed [ACC_W-1:0]   shifted;

  assign in_ready  = rst_n & ena & (state_q == IDLE);
  assign accept    = in_valid & in_ready;
  assign ch_ok     = int'(in_ch) < CHANNELS;
  assign out_data  = odata_q;
  assign out_ch    = och_q;
  assign out_valid = ov_q & ena;

  fir_delay_line #(
    .N        (N),
    .TAPS     (TAPS),
    .CHANNELS (CHANNELS),
    .CHW      (CHW),
    .AW       (AW)
  ) u_dl (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (accept & ch_ok),
    .wch   (in_ch),
    .wdata (in_data),
    .rch   (ch_q),
    .rk    (k_q),
    .rdata (x)
  );

  assign b       = coef_q[k_q];
  assign x_ext   = {{COEF_W{x[N-1]}}, x};
  assign b_ext   = {{N{b[COEF_W-1]}}, b};
  assign prod    = x_ext * b_ext;
  assign shifted = acc_q >>> SHIFT;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    acc_d   = acc_q;
    ch_d    = ch_q;
    coef_d  = coef_q;
    odata_d = odata_q;
    och_d   = och_q;
    ov_d    = ov_q;
    if (ena) begin
      ov_d = 1'b0;
      unique case (1'b1)
        (state_q == IDLE): begin
          if (coef_we && (32'(coef_addr) < TAPS)) begin
            coef_d[coef_addr] = coef_data;
          end
          if (accept && ch_ok) begin
            state_d = MAC;
            k_d     = '0;
            acc_d   = '0;
            ch_d    = in_ch;
          end
        end
        (state_q == MAC): begin
          acc_d = acc_q + ACC_W'(prod);
          k_d   = k_q + 1'b1;
          if (k_q == AW'(TAPS - 1)) begin
            state_d = DONE;
          end
        end
        (state_q == DONE): begin
          odata_d = N'(sat_trunc(MAXW'(shifted), N, SATURATE != 0));
          och_d   = ch_q;
          ov_d    = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      acc_q   <= '0;
      ch_q    <= '0;
      odata_q <= '0;
      och_q   <= '0;
      ov_q    <= 1'b0;
      for (int t = 0; t < TAPS; t++) begin
        coef_q[t] <= '0;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      ch_q    <= ch_d;
      coef_q  <= coef_d;
      odata_q <= odata_d;
      och_q   <= och_d;
      ov_q    <= ov_d;
    end
  end

endmodule

// File: tb/tb_fir_mac_n.sv
// Directed bench: four fir_mac_n variants share one stimulus stream.
// a: 32b sat, d: SHIFT=2, b/c: 16b saturating / wrapping.
module tb_fir_mac_n;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;
  logic signed [31:0] in_data = '0;
  logic [1:0] in_ch = '0;
  logic in_valid = 1'b0;
  logic coef_we = 1'b0;
  logic [1:0] coef_addr = '0;
  logic signed [31:0] coef_data = '0;

  logic a_rdy, b_rdy, c_rdy, d_rdy;
  logic a_ov, b_ov, c_ov, d_ov;
  logic [1:0] a_och, b_och, c_och, d_och;
  logic signed [31:0] a_od, d_od;
  logic signed [15:0] b_od, c_od;

  int ntests = 0;
  int nfail = 0;
  int lat;
  longint ra, rb, rc, rd, rch;
  longint sat_c [4] = '{-32767, 2, -32765, 4};

  always #5 clk = ~clk;

  fir_mac_n #(.N(32), .TAPS(4), .CHANNELS(3)) u_a (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .in_data(in_data), .in_ch(in_ch), .in_valid(in_valid),
    .in_ready(a_rdy), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .out_data(a_od), .out_ch(a_och),
    .out_valid(a_ov)
  );

  fir_mac_n #(.N(16), .TAPS(4), .CHANNELS(3), .SATURATE(1)) u_b (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .in_data(in_data[15:0]), .in_ch(in_ch), .in_valid(in_valid),
    .in_ready(b_rdy), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .out_data(b_od), .out_ch(b_och),
    .out_valid(b_ov)
  );

  fir_mac_n #(.N(16), .TAPS(4), .CHANNELS(3), .SATURATE(0)) u_c (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .in_data(in_data[15:0]), .in_ch(in_ch), .in_valid(in_valid),
    .in_ready(c_rdy), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .out_data(c_od), .out_ch(c_och),
    .out_valid(c_ov)
  );

  fir_mac_n #(.N(32), .TAPS(4), .CHANNELS(3), .SHIFT(2)) u_d (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .in_data(in_data), .in_ch(in_ch), .in_valid(in_valid),
    .in_ready(d_rdy), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .out_data(d_od), .out_ch(d_och),
    .out_valid(d_ov)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic wcoef(input logic [1:0] a, input logic signed [31:0] d);
    coef_we = 1'b1;
    coef_addr = a;
    coef_data = d;
    @(posedge clk);
    #1;
    coef_we = 1'b0;
  endtask

  task automatic set_coefs(input logic signed [31:0] c0, input logic signed [31:0] c1,
                           input logic signed [31:0] c2, input logic signed [31:0] c3);
    wcoef(2'd0, c0);
    wcoef(2'd1, c1);
    wcoef(2'd2, c2);
    wcoef(2'd3, c3);
  endtask

  // act: 1 = ena low 10 cycles, 2 = coef write mid-MAC, 3 = reset mid-MAC
  task automatic xfer(input logic [1:0] ch, input logic signed [31:0] d,
                      input int act, output int l);
    logic r;
    in_ch = ch;
    in_data = d;
    in_valid = 1'b1;
    r = 1'b0;
    for (int i = 0; i < 20 && !r; i++) begin
      @(negedge clk);
      r = a_rdy;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("accept", r, 1);
    l = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (a_ov) begin
        l = c;
        ra = a_od;
        rb = b_od;
        rc = c_od;
        rd = d_od;
        rch = a_och;
        break;
      end
      if (act == 1 && c == 2) ena = 1'b0;
      if (act == 1 && c == 12) ena = 1'b1;
      if (act == 2 && c == 2) begin
        coef_we = 1'b1;
        coef_addr = 2'd0;
        coef_data = 9;
      end
      if (act == 2 && c == 3) coef_we = 1'b0;
      if (act == 3 && c == 2) rst_n = 1'b0;
      if (act == 3 && c == 3) rst_n = 1'b1;
    end
  endtask

  task automatic flush();
    for (int i = 0; i < 4; i++) begin
      xfer(2'd0, 0, 0, lat);
      chk("flush_lat", lat, 5);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", a_rdy, 0);
    chk("rst_valid", a_ov, 0);
    chk("rst_data", a_od, 0);
    chk("rst_ch", a_och, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_ready", a_rdy, 1);

    set_coefs(1, 2, 3, 4);
    for (int i = 0; i < 6; i++) begin
      xfer(2'd0, (i == 0) ? 255 : 0, 0, lat);
      chk("imp_lat", lat, 5);
      chk("imp_data", ra, (i < 4) ? 255 * (i + 1) : 0);
      chk("imp_ch", rch, 0);
    end

    for (int i = 0; i < 9; i++) begin
      xfer(2'd1, (i == 0) ? 100 : 0, 0, lat);
      chk("ch1_lat", lat, 5);
      chk("ch1_data", ra, (i < 4) ? 100 * (i + 1) : 0);
      chk("ch1_ch", rch, 1);
      xfer(2'd0, 0, 0, lat);
      chk("ch0_data", ra, 0);
      chk("ch0_ch", rch, 0);
    end

    xfer(2'd3, 12345, 0, lat);
    chk("badch_novalid", lat, 0);
    chk("badch_ready", a_rdy, 1);
    xfer(2'd0, 255, 0, lat);
    chk("badch_next", ra, 255);
    flush();

    xfer(2'd0, 255, 2, lat);
    chk("cmac_lat", lat, 5);
    chk("cmac_cur", ra, 255);
    flush();
    xfer(2'd0, 255, 0, lat);
    chk("cmac_dropped", ra, 255);
    flush();
    wcoef(2'd0, 9);
    xfer(2'd0, 255, 0, lat);
    chk("cidle_taken", ra, 2295);
    flush();
    wcoef(2'd0, 1);

    xfer(2'd0, 255, 1, lat);
    chk("ena_lat", lat, 15);
    chk("ena_data", ra, 255);
    flush();

    set_coefs(1, 1, 1, 1);
    for (int i = 0; i < 4; i++) begin
      xfer(2'd0, -4, 0, lat);
      chk("neg_data", ra, -4 * (i + 1));
      chk("shift_data", rd, -(i + 1));
    end

    set_coefs(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    flush();
    for (int j = 0; j < 4; j++) begin
      xfer(2'd0, 32767, 0, lat);
      chk("sat16", rb, 32767);
      chk("wrap16", rc, sat_c[j]);
      if (j == 0) chk("sat32", ra, 2147483647);
    end

    xfer(2'd0, 255, 3, lat);
    chk("rstmac_novalid", lat, 0);
    chk("rstmac_data", a_od, 0);
    set_coefs(1, 2, 3, 4);
    xfer(2'd0, 255, 0, lat);
    chk("rstmac_lat", lat, 5);
    chk("rstmac_hist", ra, 255);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/fir_mac_n.md
Name: fir_mac_n

Overview:
- Multi-channel, time-multiplexed FIR filter with y[n] = sum over i = 0..TAPS-1 of b[i]*x[n-i].
- Replaces the one-multiplier-per-tap FIR with a single shared MAC that runs TAPS cycles per sample.
- Delay lines and coefficients live in runtime-writable storage. Samples arrive on a valid/ready handshake.
- Sits between the sample-rate source and the audio output path, all in the main clock domain.

Parameters:
- N, 32: signed sample width (input and output).
- COEF_W, 32: signed coefficient width.
- TAPS, 4: number of taps, >= 2.
- CHANNELS, 1: independent channels, each with its own delay line; all share one coefficient set.
- SHIFT, 0: arithmetic right shift applied to the accumulator before the output stage.
- SATURATE, 1: 1 = clamp the result to the signed N range; 0 = two's-complement truncation (wrap).

Ports:
- clk  in  1  main clock.
- rst_n  in  1  reset; asynchronous, active-low.
- ena  in  1  global enable; low freezes all state.
- in_data  in  N  signed input sample.
- in_ch  in  max(1,$clog2(CHANNELS))  channel of in_data.
- in_valid  in  1  input sample present.
- in_ready  out  1  block can accept a sample.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  $clog2(TAPS)  tap index i.
- coef_data  in  COEF_W  signed coefficient b[i].
- out_data  out  N  filtered sample.
- out_ch  out  max(1,$clog2(CHANNELS))  channel of out_data.
- out_valid  out  1  one-cycle strobe; out_data/out_ch are valid.

Behaviour:
- Reset (async, rst_n low):
  - FSM goes to IDLE.
  - All delay-line entries, coefficients, accumulator and write pointers clear to 0.
  - out_data = 0, out_ch = 0, out_valid = 0, in_ready = 0 while rst_n is low.
  - Reset asserted mid-MAC abandons that sample; no output is produced for it.
- FSM states:
  - IDLE: in_ready = ena.
  - MAC: TAPS cycles.
  - DONE: 1 cycle.
- Transitions:
  - IDLE -> MAC on the edge where in_valid && in_ready. in_data and in_ch are latched; the sample is written at that channel's write pointer, and the pointer advances modulo TAPS (wraps at TAPS-1 -> 0).
  - MAC: cycle k (k = 0..TAPS-1) accumulates b[k]*x[n-k]. The delay-line read address is (newest pointer - k) mod TAPS. The accumulator is zeroed on entry.
  - MAC -> DONE after the TAPS-th accumulate. DONE drives out_valid = 1 and updates out_data/out_ch.
  - DONE -> IDLE unconditionally.
- Latency and throughput:
  - out_valid is high in the cycle beginning TAPS+1 clocks after the accept edge.
  - One sample per TAPS+2 cycles. in_ready is low in MAC and DONE.
- Arithmetic:
  - Product width is N+COEF_W, signed.
  - Accumulator width ACC_W = N+COEF_W+$clog2(TAPS), with no internal overflow.
  - result = acc >>> SHIFT.
  - SATURATE=1: clamp to [-(2^(N-1)), 2^(N-1)-1]. SATURATE=0: keep the low N bits.
- out_data and out_ch hold their value between strobes.
- ena low:
  - FSM, pointers and accumulator freeze; in_ready = 0.
  - coef writes are ignored.
  - out_valid is forced to 0. A pending DONE strobe is issued once ena returns high.
- Coefficient writes:
  - Accepted only in IDLE with ena high.
  - Writes in MAC or DONE are dropped; the in-flight sample always uses a coherent coefficient set.
  - If a write and a sample accept occur on the same edge, both take effect. The new coefficient applies to that sample.
  - coef_addr >= TAPS (non-power-of-2 TAPS): the write is ignored.
- in_ch >= CHANNELS:
  - The sample is accepted (handshake completes) but discarded.
  - No delay-line write, no MAC, no out_valid; the FSM stays in IDLE.
- Channel isolation: a sample on channel c never alters another channel's delay line or pointer.

Decomposition:
- Package fir_pkg:
  - state enum {IDLE, MAC, DONE}.
  - ACC_W computation function.
  - saturate/truncate function (acc, N, SATURATE).
  - pointer-wrap helper.
- Sub-module fir_delay_line:
  - CHANNELS x TAPS circular buffer with per-channel write pointers.
  - One write port, one read port addressed by (ch, k).
  - Async-reset clear to zero.
- fir_mac_n holds the coefficient register file, FSM, MAC and output stage.

Test Plan:
- Impulse: TAPS=4, coefs b0..b3 = 1,2,3,4; send 255 then zeros on ch0 -> out_data 255, 510, 765, 1020, 0, 0. Each out_valid arrives exactly 5 clocks after its accept.
- Saturation: N=16, coefs all 0x7FFF_FFFF, input 32767 -> out_data 32767. Repeat with SATURATE=0 -> the low 16 bits of the exact sum.
- Negative/SHIFT: SHIFT=2, coefs 1,1,1,1, inputs -4,-4,-4,-4 -> out_data -1, -2, -3, -4.
- Channels: CHANNELS=2; impulse 100 on ch1, zeros interleaved on ch0 -> ch0 outputs all 0, ch1 outputs 100, 200, 300, 400. Pointer wrap exercised over more than 8 samples per channel.
- Coef write during MAC: write b0 = 9 while busy -> the next impulse still yields 255 (write dropped). The same write issued in IDLE -> the next impulse yields 2295.
- Reset/ena: drop rst_n mid-MAC -> out_valid never pulses and the next impulse response starts from a zero history. Drop ena for 10 cycles mid-MAC -> the result is identical but delayed by 10 cycles.
